// File: rtl/jt51_wrseq.sv
// jt51_wrseq: two-requester write FIFO feeding a sequenced YM2151 address/data bus write with busy polling.
module jt51_wrseq #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int TMO    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen_p1,
  input  logic                     req0_valid,
  input  logic [7:0]               req0_addr,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [7:0]               req1_addr,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  output logic                     cs_n,
  output logic                     wr_n,
  output logic                     a0,
  output logic [7:0]               bus_dout,
  input  logic [7:0]               bus_din,
  output logic                     idle,
  output logic                     tmo_err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = SETTLE < 2 ? 1 : $clog2(SETTLE);
  localparam int TW = TMO < 2 ? 1 : $clog2(TMO);
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_GAP, ST_DATA, ST_SETTLE, ST_POLL} state_t;
  state_t state;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [7:0] wd;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic last, full, push, pop, unused_din;
  assign unused_din = ^bus_din[6:0];
  assign full = level == LW'(DEPTH);
  // last=1 means req1 won the previous grant, so req0 takes the next tie
  assign req0_ready = rst_n && req0_valid && !full && (!req1_valid || last);
  assign req1_ready = rst_n && req1_valid && !full && !(req0_valid && last);
  assign push = req0_ready || req1_ready;
  assign pop = cen_p1 && state == ST_IDLE && level != '0;
  assign idle = level == '0 && state == ST_IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp] <= req1_ready ? {req1_addr, req1_data} : {req0_addr, req0_data};
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      last <= 1'b1;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
        last <= req1_ready;
      end
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      cs_n <= 1'b1;
      wr_n <= 1'b1;
      a0 <= 1'b0;
      bus_dout <= 8'h00;
      wd <= 8'h00;
      scnt <= '0;
      tcnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      if (cen_p1)
        case (state)
          ST_IDLE: if (level != '0) begin
            bus_dout <= mem[rp][15:8];
            wd <= mem[rp][7:0];
            cs_n <= 1'b0;
            wr_n <= 1'b0;
            a0 <= 1'b0;
            state <= ST_ADDR;
          end
          ST_ADDR: begin
            cs_n <= 1'b1;
            wr_n <= 1'b1;
            state <= ST_GAP;
          end
          ST_GAP: begin
            cs_n <= 1'b0;
            wr_n <= 1'b0;
            a0 <= 1'b1;
            bus_dout <= wd;
            state <= ST_DATA;
          end
          ST_DATA: begin
            cs_n <= 1'b1;
            wr_n <= 1'b1;
            scnt <= '0;
            tcnt <= '0;
            state <= SETTLE == 0 ? ST_POLL : ST_SETTLE;
          end
          ST_SETTLE: if (scnt == SW'(SETTLE - 1)) begin
            tcnt <= '0;
            state <= ST_POLL;
          end else scnt <= scnt + 1'b1;
          ST_POLL: if (!bus_din[7]) state <= ST_IDLE;
          else if (tcnt == TW'(TMO - 1)) begin
            state <= ST_IDLE;
            tmo_err <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
          default: state <= ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_jt51_wrseq.sv
// tb_jt51_wrseq: directed self-checking bench for jt51_wrseq.
module tb_jt51_wrseq;
  logic clk = 0, rst_n = 0, cen_fixed = 1, cen_tog = 0, ph = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [7:0] req0_addr = 0, req0_data = 0, req1_addr = 0, req1_data = 0, bus_din = 0;
  logic cen_p1, req0_ready, req1_ready, cs_n, wr_n, a0, idle, tmo_err;
  logic [7:0] bus_dout;
  logic [2:0] level;
  int passed = 0, total = 0;
  int strobes = 0, tmo_pulses = 0, wcnt = 0;
  logic cs_q = 1;
  logic [7:0] addr_q[$], data_q[$];
  int width_q[$];

  always #5 clk = ~clk;
  always @(negedge clk) ph <= ~ph;
  assign cen_p1 = cen_tog ? ph : cen_fixed;

  jt51_wrseq #(.DEPTH(4), .SETTLE(2), .TMO(64)) dut (
    .clk(clk), .rst_n(rst_n), .cen_p1(cen_p1),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .bus_dout(bus_dout), .bus_din(bus_din),
    .idle(idle), .tmo_err(tmo_err), .level(level)
  );

  // bus monitor: logs each strobe's byte and its low width in clk cycles
  always @(posedge clk) begin
    #2;
    if (tmo_err === 1'b1) tmo_pulses++;
    if (cs_n === 1'b0 && cs_q) begin
      strobes++;
      if (a0) data_q.push_back(bus_dout);
      else addr_q.push_back(bus_dout);
    end
    if (cs_n === 1'b0) wcnt++;
    else if (!cs_q) begin
      width_q.push_back(wcnt);
      wcnt = 0;
    end
    cs_q = cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, idle, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, n1;
    logic g0, g1, saw_full;
    // reset with both requesters asserting
    req0_valid = 1; req1_valid = 1;
    step(3);
    #1;
    chk("rst_cs_n", cs_n, 1); chk("rst_wr_n", wr_n, 1); chk("rst_a0", a0, 0);
    chk("rst_dout", bus_dout, 8'h00); chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
    chk("rst_idle", idle, 1); chk("rst_tmo", tmo_err, 0); chk("rst_level", level, 0);
    req0_valid = 0; req1_valid = 0; rst_n = 1;
    // single write, busy clear
    step(1);
    req0_addr = 8'h20; req0_data = 8'hC7; req0_valid = 1; #1;
    chk("a_ready0", req0_ready, 1); chk("a_ready1", req1_ready, 0);
    step(1); req0_valid = 0;
    chk("a_level", level, 1); chk("a_cs_pre", cs_n, 1);
    step(1);
    chk("a_addr_cs", cs_n, 0); chk("a_addr_wr", wr_n, 0); chk("a_addr_a0", a0, 0);
    chk("a_addr_dout", bus_dout, 8'h20); chk("a_addr_level", level, 0); chk("a_addr_idle", idle, 0);
    step(1);
    chk("a_gap_cs", cs_n, 1); chk("a_gap_wr", wr_n, 1); chk("a_gap_a0", a0, 0); chk("a_gap_dout", bus_dout, 8'h20);
    step(1);
    chk("a_data_cs", cs_n, 0); chk("a_data_wr", wr_n, 0); chk("a_data_a0", a0, 1); chk("a_data_dout", bus_dout, 8'hC7);
    step(1);
    chk("a_settle_cs", cs_n, 1);
    step(2);
    chk("a_idle_early", idle, 0);
    step(1);
    chk("a_idle_6", idle, 1);
    // busy held for 10 poll ticks delays the next write
    bus_din = 8'h80;
    step(1);
    req0_addr = 8'h31; req0_data = 8'h11; req0_valid = 1;
    step(1);
    req0_addr = 8'h32; req0_data = 8'h22;
    step(1); req0_valid = 0;
    chk("b_addr_cs", cs_n, 0); chk("b_addr_dout", bus_dout, 8'h31);
    step(2);
    base = strobes;
    step(13);
    chk("b_hold_cs", cs_n, 1); chk("b_no_strobe", strobes, base); chk("b_level", level, 1);
    bus_din = 8'h00;
    step(1);
    chk("b_release_cs", cs_n, 1);
    step(1);
    chk("b_next_cs", cs_n, 0); chk("b_next_a0", a0, 0); chk("b_next_dout", bus_dout, 8'h32);
    chk("b_no_tmo", tmo_pulses, 0);
    wait_idle("b_idle");
    // busy stuck high: timeout after 64 poll ticks, next entry proceeds
    bus_din = 8'h80;
    step(1);
    req0_addr = 8'h40; req0_data = 8'h33; req0_valid = 1;
    step(1);
    req0_addr = 8'h41; req0_data = 8'h44;
    step(1); req0_valid = 0;
    chk("c_addr_dout", bus_dout, 8'h40);
    step(68);
    chk("c_tmo_before", tmo_err, 0); chk("c_cs_before", cs_n, 1);
    step(1);
    chk("c_tmo_pulse", tmo_err, 1);
    step(1);
    chk("c_tmo_after", tmo_err, 0); chk("c_next_cs", cs_n, 0); chk("c_next_a0", a0, 0);
    chk("c_next_dout", bus_dout, 8'h41); chk("c_tmo_count", tmo_pulses, 1);
    bus_din = 8'h00;
    wait_idle("c_idle");
    // reset during DATA with three entries queued
    step(1);
    req0_valid = 1; req0_addr = 8'h80; req0_data = 8'h01;
    step(1); req0_addr = 8'h81;
    step(1); req0_addr = 8'h82;
    step(1); req0_addr = 8'h83;
    step(1); req0_valid = 0;
    chk("e_data_cs", cs_n, 0); chk("e_data_a0", a0, 1); chk("e_data_dout", bus_dout, 8'h01); chk("e_level", level, 3);
    rst_n = 0; base = strobes;
    step(1);
    chk("e_rst_cs", cs_n, 1); chk("e_rst_wr", wr_n, 1); chk("e_rst_a0", a0, 0); chk("e_rst_dout", bus_dout, 8'h00);
    chk("e_rst_level", level, 0); chk("e_rst_idle", idle, 1);
    rst_n = 1;
    step(20);
    chk("e_no_strobe", strobes, base); chk("e_idle_after", idle, 1);
    req0_valid = 1; req1_valid = 1; #1;
    chk("e_tie_r0", req0_ready, 1); chk("e_tie_r1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    step(1);
    // two requesters continuously valid, FIFO fills and order alternates
    addr_q.delete(); data_q.delete();
    n0 = 0; n1 = 0; saw_full = 0;
    for (int c = 0; c < 400 && (n0 < 6 || n1 < 6); c++) begin
      req0_valid = n0 < 6; req0_addr = 8'h50 + n0[7:0]; req0_data = 8'hA0 + n0[7:0];
      req1_valid = n1 < 6; req1_addr = 8'h60 + n1[7:0]; req1_data = 8'hB0 + n1[7:0];
      #1;
      g0 = req0_ready; g1 = req1_ready;
      chk("d_onehot", g0 && g1, 0);
      if (level == 3'd4) begin
        saw_full = 1;
        chk("d_full_r0", g0, 0); chk("d_full_r1", g1, 0);
      end
      @(negedge clk);
      n0 += int'(g0); n1 += int'(g1);
    end
    req0_valid = 0; req1_valid = 0;
    chk("d_n0", n0, 6); chk("d_n1", n1, 6); chk("d_saw_full", saw_full, 1);
    wait_idle("d_idle");
    chk("d_addr_cnt", addr_q.size(), 12); chk("d_data_cnt", data_q.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk("d_addr_order", addr_q[k], (k % 2 == 0 ? 8'h50 : 8'h60) + 8'(k / 2));
      chk("d_data_order", data_q[k], (k % 2 == 0 ? 8'hA0 : 8'hB0) + 8'(k / 2));
    end
    // cen frozen: FIFO fills then refuses; cen toggling gives 2-clk strobes
    addr_q.delete(); width_q.delete();
    cen_fixed = 0; base = strobes; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      req1_valid = 1; req1_addr = 8'h70 + n1[7:0]; req1_data = 8'hE0 + n1[7:0]; #1;
      g1 = req1_ready;
      chk("f_ready", g1, k < 4);
      @(negedge clk);
      n1 += int'(g1);
    end
    req1_valid = 0;
    chk("f_level", level, 4); chk("f_frozen_cs", cs_n, 1); chk("f_no_strobe", strobes, base); chk("f_not_idle", idle, 0);
    cen_tog = 1;
    wait_idle("f_idle");
    cen_tog = 0; cen_fixed = 1;
    chk("f_addr_cnt", addr_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("f_addr_order", addr_q[k], 8'h70 + 8'(k));
    chk("f_width_cnt", width_q.size(), 8);
    for (int k = 0; k < 8; k++) chk("f_width", width_q[k], 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jt51_wrseq.md
JT51_WRSEQ -- requirements
Module: jt51_wrseq

Interface
REQ-001 Parameter DEPTH, default 4: write FIFO entries, power of two, 2..16.
REQ-002 Parameter SETTLE, default 2: cen_p1 ticks between data strobe and first busy sample.
REQ-003 Parameter TMO, default 64: max cen_p1 ticks spent polling busy before abort.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cen_p1  in  1  clock enable; a "tick" is a clk edge with cen_p1=1.
REQ-007 req0_valid, req1_valid  in  1 each  requester has a register write pending.
REQ-008 req0_addr/req0_data, req1_addr/req1_data  in  8 each  register address and value.
REQ-009 req0_ready, req1_ready  out  1 each  grant; transfer occurs on clk edge with valid&&ready.
REQ-010 cs_n, wr_n, a0  out  1 each  chip bus strobes to the sound core.
REQ-011 bus_dout  out  8  byte driven to core din.
REQ-012 bus_din  in  8  core status byte; bit 7 = busy.
REQ-013 idle  out  1  FIFO empty and FSM in IDLE.
REQ-014 tmo_err  out  1  one-clk pulse when a busy wait aborts.
REQ-015 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Arbitration on every clk (not gated by cen_p1): at most one ready asserted per cycle, only when FIFO not full.
REQ-017 Only one valid -> that requester granted; both valid -> round-robin, grant the requester not granted last; after reset req0 wins first tie.
REQ-018 ready is combinational from valid, FIFO-full and priority pointer; ready never asserted without its valid.
REQ-019 Accepted {addr,data} pushed into FIFO same edge; FIFO full blocks push even if a pop occurs that cycle.
REQ-020 FIFO is strict FIFO order; level increments on push, decrements on pop, both -> unchanged.
REQ-021 FSM states: IDLE, ADDR, GAP, DATA, SETTLE, POLL; FSM advances only on ticks.
REQ-022 IDLE: on tick with FIFO non-empty, pop head into working register, go ADDR.
REQ-023 ADDR (one tick): cs_n=0, wr_n=0, a0=0, bus_dout=addr; next GAP.
REQ-024 GAP (one tick): cs_n=1, wr_n=1, a0 held 0, bus_dout held; next DATA.
REQ-025 DATA (one tick): cs_n=0, wr_n=0, a0=1, bus_dout=data; next SETTLE, settle counter cleared.
REQ-026 SETTLE: strobes inactive; after SETTLE ticks go POLL, timeout counter cleared.
REQ-027 POLL: sample bus_din[7] each tick; 0 -> IDLE; 1 -> increment timeout counter; counter reaching TMO -> IDLE and tmo_err pulse.
REQ-028 Strobes registered; cs_n/wr_n change only on tick edges, never glitch between ticks.
REQ-029 Outside ADDR/DATA: cs_n=1, wr_n=1.
REQ-030 idle = (level==0) && state==IDLE, registered-state derived, no combinational path from valid.
REQ-031 cen_p1 low indefinitely: FSM and strobes frozen; FIFO still accepts until full.
REQ-032 Minimum per-write latency from FIFO head to IDLE with busy already clear: 3+SETTLE+1 ticks.
REQ-033 A timed-out write is dropped, not retried; next FIFO entry proceeds normally.

Reset
REQ-034 rst_n=0 on a clk edge, regardless of cen_p1: FIFO emptied, level=0, FSM IDLE, priority to req0, counters cleared.
REQ-035 Reset values: cs_n=1, wr_n=1, a0=0, bus_dout=8'h00, req0_ready=req1_ready=0 during reset, idle=1, tmo_err=0.
REQ-036 Reset mid-write (any state): strobes inactive next edge, in-flight and queued writes discarded.

Verification
REQ-037 cen_p1=1 always, req0 writes addr 8'h20 data 8'hC7, busy held 0 -> ADDR tick a0=0/8'h20, GAP, DATA tick a0=1/8'hC7, back to IDLE 6 ticks after pop.
REQ-038 req0 and req1 valid continuously, 6 writes each, DEPTH=4 -> FIFO order alternates 0,1,0,1...; ready low while level=4.
REQ-039 bus_din[7]=1 for 10 ticks after SETTLE -> next address strobe not before busy falls; no tmo_err.
REQ-040 bus_din[7] stuck 1, TMO=64 -> tmo_err single pulse after 64 POLL ticks; next queued write issued.
REQ-041 cen_p1 toggling every other clk -> every strobe width exactly 2 clk; push while FIFO full refused.
REQ-042 rst_n low during DATA with 3 queued -> cs_n=1 next edge, level=0, idle=1, no further strobes.
